psum_collector: RTL and testbench

Consumes the 40 per-filter partial sums and their valid strobes produced by the MAC array, one 3x3x4 channel tile per pass. It accumulates `TILES` passes into full-depth convolution results. It then drains the 40 results one word per cycle over a valid/ready stream toward the output buffer or writeback path. It is the receiving end of the MAC array's sum/valid interface.

---
 rtl/psum_collector_if.sv | 28 ++
 rtl/psum_collector.sv | 150 +++++++++++++++
 tb/tb_psum_collector.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/psum_collector_if.sv
// rtl/psum_collector_if.sv - sum/valid, control, drain stream and status signals of psum_collector
interface psum_collector_if #(
  parameter int NF = 40,
  parameter int SW = 22,
  parameter int AW = 32
);
  logic [NF*SW-1:0] sum_i;
  logic [NF-1:0]    vld_i;
  logic             start;
  logic [AW-1:0]    out_data;
  logic [5:0]       out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             err_skew;
  logic             err_ovr;

  modport master (
    output sum_i, vld_i, start, out_ready,
    input  out_data, out_idx, out_valid, out_last, busy, err_skew, err_ovr
  );

  modport slave (
    input  sum_i, vld_i, start, out_ready,
    output out_data, out_idx, out_valid, out_last, busy, err_skew, err_ovr
  );
endinterface

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - accumulates TILES passes of NF partial sums, then drains NF results as a stream
// Macro PSUM_SAT_EN: saturating, sticky-clamped accumulation; undefined wraps modulo 2^AW.
module psum_collector #(
  parameter int NF    = 40,
  parameter int SW    = 22,
  parameter int AW    = 32,
  parameter int TILES = 16
) (
  input  logic           clk,
  input  logic           rst,
  psum_collector_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] LAST_PASS = 8'(TILES - 1);
  localparam logic [5:0] LAST_IDX  = 6'(NF - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [5:0]           idx_q, idx_d;
  logic                 skew_q, skew_d;
  logic                 ovr_q, ovr_d;
  logic signed [AW-1:0] acc_q   [NF];
  logic signed [AW-1:0] acc_d   [NF];
  logic signed [AW-1:0] acc_nxt [NF];

  logic pass_full;
  logic pass_skew;

  assign pass_full = &bus.vld_i;
  assign pass_skew = (|bus.vld_i) && !pass_full;

`ifdef PSUM_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic [NF-1:0]        sat_q, sat_d, sat_hit;
  logic signed [AW:0]   wide [NF];

  // A lane that has clamped once is frozen until the next start.
  always_comb begin
    for (int k = 0; k < NF; k++) begin
      wide[k]    = (AW+1)'(acc_q[k]) + (AW+1)'($signed(bus.sum_i[k*SW +: SW]));
      sat_hit[k] = wide[k][AW] != wide[k][AW-1];
      if (sat_q[k]) begin
        acc_nxt[k] = acc_q[k];
      end else if (sat_hit[k]) begin
        acc_nxt[k] = wide[k][AW] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_nxt[k] = wide[k][AW-1:0];
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NF; k++) begin
      acc_nxt[k] = acc_q[k] + AW'($signed(bus.sum_i[k*SW +: SW]));
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    skew_d  = skew_q;
    ovr_d   = ovr_q;
    acc_d   = acc_q;
`ifdef PSUM_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACC;
          cnt_d   = '0;
          skew_d  = 1'b0;
          ovr_d   = 1'b0;
          for (int k = 0; k < NF; k++) acc_d[k] = '0;
`ifdef PSUM_SAT_EN
          sat_d   = '0;
`endif
        end
      end
      S_ACC: begin
        if (pass_full) begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + 8'd1;
`ifdef PSUM_SAT_EN
          sat_d = sat_q | sat_hit;
`endif
          if (cnt_q == LAST_PASS) begin
            state_d = S_DRAIN;
            idx_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Error flags set after the start-clear so a coincident bad pass is still recorded.
    if (pass_skew) skew_d = 1'b1;
    if (pass_full && state_q != S_ACC) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      skew_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < NF; k++) acc_q[k] <= '0;
`ifdef PSUM_SAT_EN
      sat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      skew_q  <= skew_d;
      ovr_q   <= ovr_d;
      acc_q   <= acc_d;
`ifdef PSUM_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_last  = (state_q == S_DRAIN) && (idx_q == LAST_IDX);
  assign bus.out_data  = acc_q[idx_q];
  assign bus.out_idx   = idx_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err_skew  = skew_q;
  assign bus.err_ovr   = ovr_q;
endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - randomized self-checking bench for psum_collector against a lane-sum model
module tb_psum_collector;
  localparam int NF = 40;
  localparam int SW = 22;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_collector_if #(.NF(NF), .SW(SW), .AW(32)) ifa ();
  psum_collector_if #(.NF(NF), .SW(SW), .AW(24)) ifb ();

  psum_collector #(.NF(NF), .SW(SW), .AW(32), .TILES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  psum_collector #(.NF(NF), .SW(SW), .AW(24), .TILES(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint model [NF];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input longint v [NF], input logic [NF-1:0] vld);
    for (int k = 0; k < NF; k++) ifa.sum_i[k*SW +: SW] = SW'(v[k]);
    ifa.vld_i = vld;
  endtask

  task automatic rand_lanes(output longint v [NF]);
    for (int k = 0; k < NF; k++) v[k] = longint'($signed(SW'($urandom)));
  endtask

  // ready_mode: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random
  task automatic run_job_a(input bit fixed, input int ready_mode, input bit inject_skew,
                           input bit drain_start);
    longint  v [NF];
    int      idx_exp;
    int      guard;
    bit      rdy;
    bit      pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < NF; k++) model[k] = 0;

    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    check("busy_after_start", ifa.busy, 1);
    check("ovr_cleared_by_start", ifa.err_ovr, 0);
    check("skew_cleared_by_start", ifa.err_skew, 0);

    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NF; k++) v[k] = fixed ? ((p == 0) ? 100 : -30) : 0;
      if (!fixed) rand_lanes(v);
      for (int k = 0; k < NF; k++) model[k] += v[k];
      drive_a(v, '1);
      tick();
      if (inject_skew && p == 0) begin
        for (int k = 0; k < NF; k++) v[k] = 5;
        drive_a(v, 40'h00_0000_FFFF);
        tick();
        check("skew_flag", ifa.err_skew, 1);
        check("skew_still_acc", ifa.out_valid, 0);
        check("skew_no_ovr", ifa.err_ovr, 0);
      end
    end
    ifa.vld_i = '0;

    idx_exp = 0;
    guard   = 0;
    while (idx_exp < NF && guard < 400) begin
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[guard % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ifa.out_ready = rdy;
      ifa.start     = drain_start && (guard == 3);
      check("drain_valid", ifa.out_valid, 1);
      check("drain_idx", ifa.out_idx, idx_exp);
      check("drain_data", longint'($signed(ifa.out_data)), model[idx_exp]);
      check("drain_last", ifa.out_last, (idx_exp == NF - 1) ? 1 : 0);
      tick();
      guard++;
      if (rdy) idx_exp++;
    end
    ifa.out_ready = 1'b0;
    ifa.start     = 1'b0;
    check("drain_words", idx_exp, NF);
    check("idle_busy", ifa.busy, 0);
    check("idle_valid", ifa.out_valid, 0);
    check("idle_idx", ifa.out_idx, 0);
  endtask

  initial begin
    longint v [NF];
    longint sat_exp;
    int     words;

    rst = 1'b1;
    ifa.sum_i = '0; ifa.vld_i = '0; ifa.start = 1'b0; ifa.out_ready = 1'b0;
    ifb.sum_i = '0; ifb.vld_i = '0; ifb.start = 1'b0; ifb.out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", ifa.out_valid, 0);
    check("rst_last", ifa.out_last, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_skew", ifa.err_skew, 0);
    check("rst_ovr", ifa.err_ovr, 0);
    check("rst_idx", ifa.out_idx, 0);
    check("rst_data", longint'($signed(ifa.out_data)), 0);
    check("rst_b_busy", ifb.busy, 0);
    rst = 1'b0;
    tick();

    run_job_a(1'b1, 0, 1'b0, 1'b0);

    rand_lanes(v);
    drive_a(v, '1);
    tick();
    ifa.vld_i = '0;
    check("ovr_in_idle", ifa.err_ovr, 1);
    check("ovr_stays_idle", ifa.busy, 0);
    tick();
    check("ovr_sticky", ifa.err_ovr, 1);

    run_job_a(1'b0, 1, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) run_job_a(1'b0, 2, 1'b0, 1'b0);

    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    rand_lanes(v);
    drive_a(v, '1);
    tick();
    ifa.vld_i = '0;
    #2;
    rst = 1'b1;
    #2;
    check("midrst_busy", ifa.busy, 0);
    check("midrst_valid", ifa.out_valid, 0);
    check("midrst_data", longint'($signed(ifa.out_data)), 0);
    check("midrst_idx", ifa.out_idx, 0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_valid", ifa.out_valid, 0);
    run_job_a(1'b0, 0, 1'b0, 1'b0);

`ifdef PSUM_SAT_EN
    sat_exp = 8388607;
`else
    sat_exp = -8;
`endif
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int k = 0; k < NF; k++) ifb.sum_i[k*SW +: SW] = 22'h1F_FFFF;
    ifb.vld_i = '1;
    for (int p = 0; p < 8; p++) tick();
    ifb.vld_i = '0;
    check("sat_b_no_ovr", ifb.err_ovr, 0);
    ifb.out_ready = 1'b1;
    words = 0;
    for (int c = 0; c < 60 && ifb.out_valid; c++) begin
      check("sat_b_data", longint'($signed(ifb.out_data)), sat_exp);
      tick();
      words++;
    end
    ifb.out_ready = 1'b0;
    check("sat_b_words", words, NF);
    check("sat_b_idle", ifb.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
